envia_movimentos: RTL and testbench

ENVIA_MOVIMENTOS -- requirements
Module: envia_movimentos

---
 rtl/envia_movimentos.sv | 171 +++++++++++++++++
 tb/tb_envia_movimentos.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/envia_movimentos.sv
`timescale 1ns/1ps
// envia_movimentos: buffers 3-bit move codes and sends them as ASCII characters on an 8N1 serial line.
// Optional macro ENVIA_TERMINADOR_EN appends a line-feed (0x0A) frame after the last move.
module envia_movimentos #(
  parameter int CLK_DIV = 434,
  parameter int DEPTH   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       we_mov,
  input  logic [2:0] movimento,
  output logic       saida_serial,
  output logic       pronto,
  output logic       cheio,
  output logic [2:0] db_estado
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);

  typedef enum logic [2:0] {
    st_inicial    = 3'd0,
    st_carrega    = 3'd1,
    st_transmite  = 3'd2,
    st_proximo    = 3'd3,
`ifdef ENVIA_TERMINADOR_EN
    st_terminador = 3'd4,
`endif
    st_final      = 3'd5
  } estado_t;

`ifdef ENVIA_TERMINADOR_EN
  localparam estado_t ST_FIM = st_terminador;
`else
  localparam estado_t ST_FIM = st_final;
`endif

  function automatic logic [7:0] ascii_de(input logic [2:0] codigo);
    case (codigo)
      3'd0:    ascii_de = 8'h55;
      3'd1:    ascii_de = 8'h44;
      3'd2:    ascii_de = 8'h4C;
      3'd3:    ascii_de = 8'h52;
      3'd4:    ascii_de = 8'h46;
      3'd5:    ascii_de = 8'h42;
      default: ascii_de = 8'h3F;
    endcase
  endfunction

  estado_t         state_r, state_s;
  logic [2:0]      mem_r [DEPTH];
  logic [CW-1:0]   count_r, count_s, rd_ptr_r, rd_next_s;
  logic [BW-1:0]   baud_r;
  logic [3:0]      bit_r;
  logic [7:0]      byte_r, tx_byte_s;
  logic [2:0]      idx_s;
  logic            saida_r, pronto_r, cheio_r;
  logic            wr_ok_s, entra_final_s, tx_ativo_s, tx_bit_s, baud_fim_s, frame_fim_s;

  assign rd_next_s     = rd_ptr_r + CW'(1);
  assign wr_ok_s       = we_mov && !cheio_r && ((state_r == st_inicial) || (state_r == st_final));
  assign entra_final_s = (state_s == st_final) && (state_r != st_final);
  assign baud_fim_s    = (baud_r == BAUD_LAST);
  assign frame_fim_s   = baud_fim_s && (bit_r == 4'd9);

  // Next-state logic; a write and iniciar in the same cycle both take effect.
  always_comb begin
    state_s = state_r;
    case (state_r)
      st_inicial, st_final: begin
        if (iniciar) state_s = st_carrega;
        else         state_s = state_r;
      end
      st_carrega: begin
        if (rd_ptr_r == count_r) state_s = ST_FIM;
        else                     state_s = st_transmite;
      end
      st_transmite: begin
        if (frame_fim_s) state_s = st_proximo;
        else             state_s = st_transmite;
      end
      st_proximo: begin
        if (rd_next_s == count_r) state_s = ST_FIM;
        else                      state_s = st_carrega;
      end
`ifdef ENVIA_TERMINADOR_EN
      st_terminador: begin
        if (frame_fim_s) state_s = st_final;
        else             state_s = st_terminador;
      end
`endif
      default: state_s = st_inicial;
    endcase
  end

  // Buffer occupancy: cleared on entry to final, bumped by accepted writes.
  always_comb begin
    count_s = count_r;
    if (entra_final_s)  count_s = {CW{1'b0}};
    else if (wr_ok_s)   count_s = count_r + CW'(1);
    else                count_s = count_r;
  end

  // Serial bit selection: start, 8 data bits LSB first, stop.
  always_comb begin
    tx_ativo_s = (state_r == st_transmite);
    tx_byte_s  = byte_r;
`ifdef ENVIA_TERMINADOR_EN
    if (state_r == st_terminador) begin
      tx_ativo_s = 1'b1;
      tx_byte_s  = 8'h0A;
    end else begin
      tx_byte_s  = byte_r;
    end
`endif
    idx_s = 3'(bit_r - 4'd1);
    case (bit_r)
      4'd0:    tx_bit_s = 1'b0;
      4'd9:    tx_bit_s = 1'b1;
      default: tx_bit_s = tx_byte_s[idx_s];
    endcase
  end

  // Control registers, baud/bit counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= st_inicial;
      count_r  <= {CW{1'b0}};
      rd_ptr_r <= {CW{1'b0}};
      baud_r   <= {BW{1'b0}};
      bit_r    <= 4'd0;
      byte_r   <= 8'h00;
      saida_r  <= 1'b1;
      pronto_r <= 1'b0;
      cheio_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      count_r  <= count_s;
      cheio_r  <= (count_s == FULL);
      pronto_r <= entra_final_s;
      saida_r  <= tx_ativo_s ? tx_bit_s : 1'b1;
      if (entra_final_s)               rd_ptr_r <= {CW{1'b0}};
      else if (state_r == st_proximo)  rd_ptr_r <= rd_next_s;
      if (state_r == st_carrega)       byte_r <= ascii_de(mem_r[rd_ptr_r[AW-1:0]]);
      if (tx_ativo_s) begin
        if (baud_fim_s) begin
          baud_r <= {BW{1'b0}};
          bit_r  <= (bit_r == 4'd9) ? 4'd0 : bit_r + 4'd1;
        end else begin
          baud_r <= baud_r + BW'(1);
        end
      end else begin
        baud_r <= {BW{1'b0}};
        bit_r  <= 4'd0;
      end
    end
  end

  // Move buffer write port; the write address is the current occupancy.
  always_ff @(posedge clock) begin
    if (wr_ok_s) mem_r[count_r[AW-1:0]] <= movimento;
  end

  assign saida_serial = saida_r;
  assign pronto       = pronto_r;
  assign cheio        = cheio_r;
  assign db_estado    = state_r;
endmodule

// File: tb/tb_envia_movimentos.sv
`timescale 1ns/1ps
// Self-checking bench for envia_movimentos (CLK_DIV=4, DEPTH=4): serial receiver feeding a byte scoreboard.
module tb_envia_movimentos;
  localparam int CD = 4;
  localparam int DP = 4;
  localparam int FRAME = 10 * CD;

  logic       clock = 1'b0;
  logic       reset = 1'b1, iniciar = 1'b0, we_mov = 1'b0;
  logic [2:0] movimento = 3'd0;
  logic       saida_serial, pronto, cheio;
  logic [2:0] db_estado;

  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  int start_q[$];
  int cyc = 0, pronto_cnt = 0, pronto_cyc = 0, rx_cnt = 0, low_cnt = 0;
  int mcount = 0, e0 = 0, p0 = 0;
  bit busy = 1'b0;
  int k = 0;
  logic [7:0] sh = 8'h00, exp_b = 8'h00;

  envia_movimentos #(.CLK_DIV(CD), .DEPTH(DP)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .we_mov(we_mov),
    .movimento(movimento), .saida_serial(saida_serial), .pronto(pronto),
    .cheio(cheio), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] ascii_exp(input logic [2:0] c);
    case (c)
      3'd0: return 8'h55;
      3'd1: return 8'h44;
      3'd2: return 8'h4C;
      3'd3: return 8'h52;
      3'd4: return 8'h46;
      3'd5: return 8'h42;
      default: return 8'h3F;
    endcase
  endfunction

  // Cycles from the edge sampling iniciar to the edge raising pronto.
  function automatic int exp_lat(input int n);
`ifdef ENVIA_TERMINADOR_EN
    if (n == 0) return 1 + FRAME;
    return (FRAME + 2) * n + FRAME;
`else
    if (n == 0) return 1;
    return (FRAME + 2) * n;
`endif
  endfunction

`ifdef ENVIA_TERMINADOR_EN
  localparam int LF_LOW = 7 * CD;
`else
  localparam int LF_LOW = 0;
`endif

  // Line monitor: samples 1 ns after each edge, decodes 8N1 frames, checks them against the scoreboard.
  always @(posedge clock) begin
    cyc = cyc + 1;
    #1;
    if (pronto === 1'b1) begin pronto_cnt++; pronto_cyc = cyc; end
    if (saida_serial !== 1'b1) low_cnt++;
    if (reset === 1'b1) begin
      busy = 1'b0;
    end else if (!busy) begin
      if (saida_serial === 1'b0) begin busy = 1'b1; k = 0; sh = 8'h00; start_q.push_back(cyc); end
    end else begin
      k++;
      if (k >= CD + CD / 2 && k < 9 * CD && (k % CD) == CD / 2) sh[k / CD - 1] = saida_serial;
      if (k == 9 * CD + CD / 2) begin
        busy = 1'b0;
        rx_cnt++;
        checks++;
        if (saida_serial !== 1'b1) begin errors++; $display("FAIL stop_bit got %b want 1", saida_serial); end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rx_byte unexpected byte %h", sh);
        end else begin
          exp_b = exp_q.pop_front();
          if (sh !== exp_b) begin errors++; $display("FAIL rx_byte got %h want %h", sh, exp_b); end
        end
      end
    end
  end

  task automatic write_mov(input logic [2:0] c);
    @(negedge clock); we_mov = 1'b1; movimento = c;
    @(negedge clock); we_mov = 1'b0;
    if (mcount < DP) begin exp_q.push_back(ascii_exp(c)); mcount++; end
  endtask

  task automatic run_tx(input bit with_wr, input logic [2:0] c, output int ntx);
    start_q.delete();
    @(negedge clock); iniciar = 1'b1;
    if (with_wr) begin we_mov = 1'b1; movimento = c; end
    @(negedge clock); iniciar = 1'b0; we_mov = 1'b0;
    e0 = cyc; p0 = pronto_cnt;
    if (with_wr && mcount < DP) begin exp_q.push_back(ascii_exp(c)); mcount++; end
`ifdef ENVIA_TERMINADOR_EN
    exp_q.push_back(8'h0A);
`endif
    ntx = mcount;
    mcount = 0;
  endtask

  task automatic wait_pronto(output int lat);
    lat = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (pronto_cnt != p0) begin lat = pronto_cyc - e0; break; end
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (saida_serial !== 1'b1) begin errors++; $display("FAIL reset_saida got %b want 1", saida_serial); end
    checks++; if (pronto !== 1'b0) begin errors++; $display("FAIL reset_pronto got %b want 0", pronto); end
    checks++; if (cheio !== 1'b0) begin errors++; $display("FAIL reset_cheio got %b want 0", cheio); end
    checks++; if (db_estado !== 3'd0) begin errors++; $display("FAIL reset_estado got %0d want 0", db_estado); end
    reset = 1'b0;
  endtask

  task automatic test_empty();
    int n, lat, l0;
    l0 = low_cnt;
    run_tx(1'b0, 3'd0, n);
    wait_pronto(lat);
    checks++; if (lat != exp_lat(0)) begin errors++; $display("FAIL empty_latency got %0d want %0d", lat, exp_lat(0)); end
    checks++; if (low_cnt - l0 != LF_LOW) begin errors++; $display("FAIL empty_low_samples got %0d want %0d", low_cnt - l0, LF_LOW); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL empty_missing got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_single();
    int n, lat;
    write_mov(3'd3);
    run_tx(1'b0, 3'd0, n);
    checks++; if (db_estado !== 3'd1) begin errors++; $display("FAIL single_carrega got %0d want 1", db_estado); end
    @(negedge clock);
    checks++; if (saida_serial !== 1'b1) begin errors++; $display("FAIL single_prestart got %b want 1", saida_serial); end
    @(negedge clock);
    checks++; if (saida_serial !== 1'b0) begin errors++; $display("FAIL single_start got %b want 0", saida_serial); end
    wait_pronto(lat);
    checks++; if (lat != exp_lat(1)) begin errors++; $display("FAIL single_latency got %0d want %0d", lat, exp_lat(1)); end
    checks++; if (pronto_cnt != p0 + 1) begin errors++; $display("FAIL single_pronto_pulses got %0d want 1", pronto_cnt - p0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_missing got %0d want 0", exp_q.size()); end
    checks++; if (db_estado !== 3'd5) begin errors++; $display("FAIL single_final got %0d want 5", db_estado); end
  endtask

  task automatic test_back_to_back();
    int n, lat;
    write_mov(3'd0);
    write_mov(3'd5);
    run_tx(1'b1, 3'd7, n);
    wait_pronto(lat);
    checks++; if (lat != exp_lat(3)) begin errors++; $display("FAIL b2b_latency got %0d want %0d", lat, exp_lat(3)); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missing got %0d want 0", exp_q.size()); end
    checks++;
    if (start_q.size() < 3) begin
      errors++; $display("FAIL b2b_frames got %0d want 3", start_q.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (start_q[i] - start_q[i-1] != FRAME + 2) begin
          errors++; $display("FAIL b2b_gap got %0d want %0d", start_q[i] - start_q[i-1], FRAME + 2);
        end
      end
    end
    run_tx(1'b0, 3'd0, n);
    wait_pronto(lat);
    checks++; if (lat != exp_lat(0)) begin errors++; $display("FAIL b2b_count_cleared got %0d want %0d", lat, exp_lat(0)); end
  endtask

  task automatic test_full();
    int n, lat;
    logic [2:0] cods [5] = '{3'd1, 3'd2, 3'd4, 3'd6, 3'd3};
    for (int i = 0; i < 5; i++) begin
      write_mov(cods[i]);
      checks++;
      if (cheio !== (i >= 3)) begin errors++; $display("FAIL full_cheio write %0d got %b want %b", i, cheio, (i >= 3)); end
    end
    run_tx(1'b0, 3'd0, n);
    wait_pronto(lat);
    checks++; if (lat != exp_lat(4)) begin errors++; $display("FAIL full_latency got %0d want %0d", lat, exp_lat(4)); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL full_missing got %0d want 0", exp_q.size()); end
    checks++; if (cheio !== 1'b0) begin errors++; $display("FAIL full_cheio_after got %b want 0", cheio); end
  endtask

  task automatic test_ignore_during_tx();
    int n, lat;
    write_mov(3'd2);
    write_mov(3'd4);
    run_tx(1'b0, 3'd0, n);
    repeat (15) @(negedge clock);
    iniciar = 1'b1; we_mov = 1'b1; movimento = 3'd5;
    @(negedge clock);
    iniciar = 1'b0; we_mov = 1'b0;
    checks++; if (db_estado !== 3'd2) begin errors++; $display("FAIL ignore_state got %0d want 2", db_estado); end
    wait_pronto(lat);
    checks++; if (lat != exp_lat(2)) begin errors++; $display("FAIL ignore_latency got %0d want %0d", lat, exp_lat(2)); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ignore_missing got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int n, r0, pc, l0;
    write_mov(3'd0);
    run_tx(1'b0, 3'd0, n);
    for (int i = 0; i < 10 && saida_serial !== 1'b0; i++) @(negedge clock);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++; if (saida_serial !== 1'b1) begin errors++; $display("FAIL midreset_saida got %b want 1", saida_serial); end
    checks++; if (db_estado !== 3'd0) begin errors++; $display("FAIL midreset_estado got %0d want 0", db_estado); end
    reset = 1'b0;
    exp_q.delete();
    mcount = 0;
    r0 = rx_cnt; pc = pronto_cnt; l0 = low_cnt;
    repeat (100) @(negedge clock);
    checks++; if (pronto_cnt != pc) begin errors++; $display("FAIL midreset_pronto got %0d want %0d", pronto_cnt, pc); end
    checks++; if (rx_cnt != r0) begin errors++; $display("FAIL midreset_bytes got %0d want %0d", rx_cnt, r0); end
    checks++; if (low_cnt != l0) begin errors++; $display("FAIL midreset_line_low got %0d want %0d", low_cnt - l0, 0); end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_single();
    test_back_to_back();
    test_full();
    test_ignore_during_tx();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
